eig_sequencer: RTL and testbench

- Central controller for the frame pipeline: parameter loader → eigen core → output loader.
- Each time the loader reports a valid alpha/beta pair, the block:
  - starts the core and waits for its result;
  - latches the regime;
  - starts the output loader and waits for it to drain.
- Per-stage watchdog timers catch a hung core or a hung output loader.
- Holds the loader while a frame is in flight, flags dropped frames and counts completed frames.

---
 rtl/eig_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_eig_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/eig_sequencer.sv
// eig_sequencer
// Frame controller for the parameter loader -> eigen core -> output loader chain.
// When the loader presents a fresh alpha/beta pair, the block starts the core,
// latches the regime the core returns, starts the output loader and waits for it
// to drain. It holds the loader while a frame is in flight. Each wait state has
// its own watchdog.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ena              enable; when low the FSM, timer and counters freeze
//   pl_valid         loader has a fresh pair (1-cycle pulse)
//   pl_hold          loader must not overwrite alpha/beta
//   core_start       1-cycle start pulse to the eigen core
//   core_done        core result valid (1-cycle pulse)
//   core_regime[2:0] regime from the core, valid with core_done
//   regime_q[2:0]    regime latched at core_done
//   ol_start         1-cycle start pulse to the output loader
//   ol_busy          output loader busy
//   clr_err          leave ERROR and clear the sticky flags
//   busy             controller not idle
//   err              in ERROR
//   err_code[1:0]    00 none, 01 core timeout, 10 output loader timeout
//   overrun          sticky: a frame was dropped because the controller was busy
//   frame_cnt[7:0]   completed frames, wraps
module eig_sequencer #(
  parameter int CORE_TIMEOUT = 200,
  parameter int OL_TIMEOUT   = 64,
  parameter int TMR_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       pl_valid,
  output logic       pl_hold,
  output logic       core_start,
  input  logic       core_done,
  input  logic [2:0] core_regime,
  output logic [2:0] regime_q,
  output logic       ol_start,
  input  logic       ol_busy,
  input  logic       clr_err,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_CORE,
    S_WAIT_CORE,
    S_START_OL,
    S_WAIT_OL,
    S_ERROR
  } state_t;

  localparam logic [TMR_W-1:0] CORE_LAST = TMR_W'(CORE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] OL_LAST   = TMR_W'(OL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_pl_hold;
  logic             r_core_start;
  logic             r_ol_start;
  logic             r_busy;
  logic             r_err;
  logic             r_overrun;
  logic [2:0]       r_regime;
  logic [1:0]       r_err_code;
  logic [7:0]       r_frame_cnt;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
    return (t == TMR_MAX) ? t : t + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_pl_hold    <= 1'b0;
      r_core_start <= 1'b0;
      r_ol_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_overrun    <= 1'b0;
      r_regime     <= '0;
      r_err_code   <= '0;
      r_frame_cnt  <= '0;
    end else if (ena) begin
      // Sticky overrun: cleared by clr_err, but a frame dropped on the same
      // edge is still reported.
      if (clr_err && r_state != S_ERROR)
        r_overrun <= 1'b0;
      if (pl_valid && r_state != S_IDLE && r_state != S_ERROR)
        r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (pl_valid) begin
            r_state      <= S_START_CORE;
            r_core_start <= 1'b1;
            r_pl_hold    <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_START_CORE: begin
          r_state      <= S_WAIT_CORE;
          r_core_start <= 1'b0;
          r_timer      <= '0;
        end
        S_WAIT_CORE: begin
          // A done arriving on the timeout cycle still completes the frame.
          if (core_done) begin
            r_regime   <= core_regime;
            r_state    <= S_START_OL;
            r_ol_start <= 1'b1;
          end else if (r_timer == CORE_LAST) begin
            r_state    <= S_ERROR;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
          end else begin
            r_timer <= tmr_inc(r_timer);
          end
        end
        S_START_OL: begin
          r_state    <= S_WAIT_OL;
          r_ol_start <= 1'b0;
          r_timer    <= '0;
        end
        S_WAIT_OL: begin
          // timer==0 marks the first WAIT_OL cycle, before the loader has had
          // time to raise ol_busy, so a low ol_busy there means nothing.
          if (r_timer != '0 && !ol_busy) begin
            r_state     <= S_IDLE;
            r_pl_hold   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end else if (r_timer == OL_LAST) begin
            r_state    <= S_ERROR;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end else begin
            r_timer <= tmr_inc(r_timer);
          end
        end
        S_ERROR: begin
          if (clr_err) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_overrun  <= 1'b0;
            r_pl_hold  <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pl_hold <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // The start registers stay set for the whole START_* state; gating with ena
  // suppresses the pulse while frozen and emits it in the first enabled cycle,
  // which is also the cycle the state moves on.
  assign core_start = r_core_start & ena;
  assign ol_start   = r_ol_start & ena;
  assign pl_hold    = r_pl_hold;
  assign regime_q   = r_regime;
  assign busy       = r_busy;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign overrun    = r_overrun;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_eig_sequencer.sv
// Testbench for eig_sequencer: table-driven frames with a regime/frame-count
// scoreboard, plus hand sequences for timeouts, overrun, freeze, reset and wrap.
module tb_eig_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       pl_valid = 1'b0;
  logic       pl_hold;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [2:0] core_regime = 3'd0;
  logic [2:0] regime_q;
  logic       ol_start;
  logic       ol_busy = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic       overrun;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  eig_sequencer #(.CORE_TIMEOUT(200), .OL_TIMEOUT(64), .TMR_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pl_valid(pl_valid), .pl_hold(pl_hold),
    .core_start(core_start), .core_done(core_done), .core_regime(core_regime),
    .regime_q(regime_q), .ol_start(ol_start), .ol_busy(ol_busy),
    .clr_err(clr_err), .busy(busy), .err(err), .err_code(err_code),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         d;     // cycle core_done is driven (pl_valid in cycle 0)
    logic [2:0] r;     // regime returned with core_done
    int         b;     // cycles ol_busy is high, starting 3 cycles after done
    int         ols;   // expected ol_start cycle
    int         idle;  // expected first cycle back in IDLE
  } vec_t;

  typedef struct {
    logic [2:0] r;
    logic [7:0] cnt;
  } sb_t;

  vec_t       tbl[6];
  sb_t        sbq[$];
  logic [7:0] exp_frames = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after the rising edge, return at the falling edge where
  // the caller samples outputs for this cycle.
  task automatic drive(input logic r, input logic en, input logic pv, input logic dn,
                       input logic [2:0] rg, input logic ob, input logic cl);
    @(posedge clk);
    #1;
    rst = r; ena = en; pl_valid = pv; core_done = dn;
    core_regime = rg; ol_busy = ob; clr_err = cl;
    @(negedge clk);
  endtask

  task automatic run_frame(input int d, input logic [2:0] r, input int b,
                           input int ols, input int idle, input int pv2);
    sb_t s;
    for (int k = 0; k <= idle; k++) begin
      drive(1'b0, 1'b1, (k == 0) || (k == pv2), (k == d),
            (k == d) ? r : 3'($urandom), (k >= d + 3) && (k < d + 3 + b), 1'b0);
      if (k == 0) begin
        exp_frames = exp_frames + 8'd1;
        sbq.push_back('{r, exp_frames});
      end
      chk("core_start", core_start, (k == 1));
      chk("ol_start", ol_start, (k == ols));
      chk("busy", busy, (k >= 1) && (k < idle));
      chk("pl_hold", pl_hold, (k >= 1) && (k < idle));
      chk("err", err, 1'b0);
      chk("overrun", overrun, (pv2 >= 0) && (k > pv2));
      if (k >= ols) chk("regime_hold", regime_q, r);
      if (k == idle) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          s = sbq.pop_front();
          chk("sb_regime", regime_q, s.r);
          chk("sb_frame_cnt", frame_cnt, s.cnt);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{10,  3'b101, 8, 11,  22};
    tbl[1] = '{2,   3'b011, 0, 3,   6};
    tbl[2] = '{5,   3'b111, 3, 6,   12};
    tbl[3] = '{3,   3'b000, 1, 4,   8};
    tbl[4] = '{20,  3'b010, 0, 21,  24};
    tbl[5] = '{201, 3'b110, 2, 202, 207};

    // Reset state
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pl_hold", pl_hold, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_ol_start", ol_start, 1'b0);
    chk("rst_regime", regime_q, 3'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);

    // Table-driven frames (last row: core_done on the final timeout cycle)
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].d, tbl[i].r, tbl[i].b, tbl[i].ols, tbl[i].idle, -1);

    // Overrun: second pl_valid in WAIT_CORE, then clr_err in IDLE
    run_frame(8, 3'b100, 2, 9, 14, 5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("ovr_before_clr", overrun, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("ovr_after_clr", overrun, 1'b0);
    chk("ovr_frame_cnt", frame_cnt, exp_frames);

    // Enable freeze: START_CORE frozen 1..5, WAIT_CORE frozen 20..69
    for (int k = 0; k <= 258; k++) begin
      drive(1'b0, !((k >= 1 && k <= 5) || (k >= 20 && k <= 69)),
            (k == 0) || (k == 2), (k == 3) || (k == 30), 3'b111, 1'b0, 1'b0);
      chk("frz_core_start", core_start, (k == 6));
      chk("frz_err", err, (k >= 257));
      chk("frz_busy", busy, (k >= 1));
      chk("frz_overrun", overrun, 1'b0);
      if (k == 257) chk("frz_err_code", err_code, 2'b01);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("frz_clr_err", err, 1'b0);
    chk("frz_clr_busy", busy, 1'b0);

    // Core hang: ERROR after 200 WAIT_CORE cycles, pl_valid ignored, clr_err
    for (int k = 0; k <= 206; k++) begin
      drive(1'b0, 1'b1, (k == 0) || (k == 203), 1'b0, 3'($urandom), 1'b0, (k == 205));
      chk("ch_core_start", core_start, (k == 1));
      chk("ch_err", err, (k >= 202) && (k <= 205));
      chk("ch_busy", busy, (k >= 1) && (k <= 205));
      chk("ch_overrun", overrun, 1'b0);
      if (k == 202) chk("ch_err_code", err_code, 2'b01);
      if (k == 204) chk("ch_pl_hold", pl_hold, 1'b1);
      if (k == 206) chk("ch_err_code_clr", err_code, 2'b00);
    end

    // Output loader hang, then pl_valid together with clr_err in ERROR
    for (int k = 0; k <= 71; k++) begin
      drive(1'b0, 1'b1, (k == 0) || (k == 69), (k == 2), 3'b011, (k >= 4), (k == 69));
      chk("oh_core_start", core_start, (k == 1));
      chk("oh_ol_start", ol_start, (k == 3));
      chk("oh_err", err, (k == 68) || (k == 69));
      chk("oh_busy", busy, (k >= 1) && (k <= 69));
      chk("oh_overrun", overrun, 1'b0);
      if (k == 68) chk("oh_err_code", err_code, 2'b10);
      if (k == 70) chk("oh_err_code_clr", err_code, 2'b00);
      if (k == 71) chk("oh_frame_cnt", frame_cnt, exp_frames);
    end

    // Reset in WAIT_OL abandons the frame
    for (int k = 0; k <= 20; k++) begin
      drive((k == 6), 1'b1, (k == 0), (k == 2) || (k == 12), 3'b101,
            (k >= 4) && (k != 10), 1'b0);
      if (k == 3) chk("rm_ol_start", ol_start, 1'b1);
      if (k == 5) chk("rm_busy_pre", busy, 1'b1);
      if (k == 7) begin
        chk("rm_regime", regime_q, 3'd0);
        chk("rm_frame_cnt", frame_cnt, 8'd0);
        chk("rm_pl_hold", pl_hold, 1'b0);
        chk("rm_err", err, 1'b0);
        chk("rm_err_code", err_code, 2'b00);
        chk("rm_overrun", overrun, 1'b0);
      end
      if (k >= 7) begin
        chk("rm_busy", busy, 1'b0);
        chk("rm_core_start", core_start, 1'b0);
        chk("rm_ol_start_after", ol_start, 1'b0);
      end
    end
    exp_frames = 8'd0;
    sbq.delete();

    // 256 back-to-back frames: counter wraps to 0
    for (int i = 0; i < 256; i++)
      run_frame(2, 3'(i), 0, 3, 6, -1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("wrap_frame_cnt", frame_cnt, 8'd0);
    chk("sb_leftover", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
